clk_reset_seq: RTL



---
 rtl/clk_reset_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/clk_reset_seq.sv
// Reset sequencer around the MMCM: pulses the MMCM reset, filters its lock
// indication and releases sys_rst only after lock has been stable long enough.
module clk_reset_seq #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 100000,
  parameter int LOCK_FILTER      = 4,
  parameter int HOLD_CYCLES      = 1024,
  parameter int CNT_W            = 20
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       locked,
  output logic       mmcm_rst,
  output logic       sys_rst,
  output logic       sys_ready,
  output logic       lock_lost,
  output logic [3:0] retries
);

  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);

  localparam logic [PW-1:0]    PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [FW-1:0]    FILT_DONE  = FW'(LOCK_FILTER);

  typedef enum logic [2:0] {
    S_PULSE,
    S_WAIT_LOCK,
    S_FILTER,
    S_HOLD,
    S_RUN
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    pcnt_q;
  logic [CNT_W-1:0] tcnt_q;
  logic [FW-1:0]    fcnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [3:0]       retries_q;
  logic             mmcm_rst_q;
  logic             sys_rst_q;
  logic             sys_ready_q;
  logic             lock_lost_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             locked_s;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'h1;
  endfunction

  // locked is asynchronous to clk100; only the second flop feeds the FSM
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PULSE;
      pcnt_q      <= '0;
      tcnt_q      <= '0;
      fcnt_q      <= '0;
      hcnt_q      <= '0;
      retries_q   <= '0;
      mmcm_rst_q  <= 1'b1;
      sys_rst_q   <= 1'b1;
      sys_ready_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_lost_q <= 1'b0;
      case (state_q)
        S_PULSE: begin
          if (pcnt_q == PULSE_LAST) begin
            state_q    <= S_WAIT_LOCK;
            pcnt_q     <= '0;
            tcnt_q     <= '0;
            fcnt_q     <= '0;
            mmcm_rst_q <= 1'b0;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          tcnt_q <= tcnt_q + 1'b1;
          if (locked_s) begin
            state_q <= S_FILTER;
            fcnt_q  <= FW'(1);
          end else if (tcnt_q >= TO_LAST) begin
            state_q    <= S_PULSE;
            pcnt_q     <= '0;
            mmcm_rst_q <= 1'b1;
            retries_q  <= sat_inc(retries_q);
          end
        end
        // tcnt is not cleared on a filter drop, so a glitchy lock still times out
        S_FILTER: begin
          tcnt_q <= tcnt_q + 1'b1;
          if (locked_s && fcnt_q == FILT_DONE) begin
            state_q <= S_HOLD;
            hcnt_q  <= '0;
          end else if (tcnt_q >= TO_LAST) begin
            state_q    <= S_PULSE;
            pcnt_q     <= '0;
            mmcm_rst_q <= 1'b1;
            retries_q  <= sat_inc(retries_q);
          end else if (!locked_s) begin
            state_q <= S_WAIT_LOCK;
            fcnt_q  <= '0;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (!locked_s) begin
            state_q     <= S_PULSE;
            pcnt_q      <= '0;
            mmcm_rst_q  <= 1'b1;
            lock_lost_q <= 1'b1;
            retries_q   <= sat_inc(retries_q);
          end else if (hcnt_q == HOLD_LAST) begin
            state_q     <= S_RUN;
            sys_rst_q   <= 1'b0;
            sys_ready_q <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_q     <= S_PULSE;
            pcnt_q      <= '0;
            mmcm_rst_q  <= 1'b1;
            sys_rst_q   <= 1'b1;
            sys_ready_q <= 1'b0;
            lock_lost_q <= 1'b1;
            retries_q   <= sat_inc(retries_q);
          end
        end
        default: begin
          state_q     <= S_PULSE;
          pcnt_q      <= '0;
          mmcm_rst_q  <= 1'b1;
          sys_rst_q   <= 1'b1;
          sys_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign mmcm_rst  = mmcm_rst_q;
  assign sys_rst   = sys_rst_q;
  assign sys_ready = sys_ready_q;
  assign lock_lost = lock_lost_q;
  assign retries   = retries_q;

endmodule
